// File: rtl/unalign_samples.sv
// unalign_samples: TX-side inverse of sample alignment. A packet whose first
// sample arrives on lane 0 is re-emitted starting on lane s (latched from i_shift
// on the first word). Samples pushed past the top lane are carried into the next
// output word. A trailing flush word drains the carry when s != 0.
module unalign_samples #(
    parameter int unsigned SAMP_W = 16,
    parameter int unsigned SPC    = 4,
    parameter int unsigned USER_W = 16,
    localparam int unsigned SHIFT_W = (SPC > 1) ? $clog2(SPC) : 1,
    localparam int unsigned DATA_W  = SAMP_W * SPC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [USER_W-1:0]  i_user,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_last,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [DATA_W-1:0]  o_data,
    output logic [USER_W-1:0]  o_user,
    output logic [SPC-1:0]     o_mask,
    output logic               o_last,
    output logic               o_valid,
    input  logic               o_ready
);

    localparam logic [1:0] StSop   = 2'd0;
    localparam logic [1:0] StBody  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]  carry_q, carry_d;
    logic [DATA_W-1:0]  o_data_q, o_data_d;
    logic [USER_W-1:0]  o_user_q, o_user_d;
    logic [SPC-1:0]     o_mask_q, o_mask_d;
    logic               o_last_q, o_last_d;
    logic               o_valid_q, o_valid_d;

    logic [SHIFT_W-1:0]  in_shift;
    logic [SHIFT_W-1:0]  sh_s;
    logic [DATA_W-1:0]   sh_cur;
    logic [DATA_W-1:0]   sh_prev;
    logic [2*DATA_W-1:0] sh_wide;
    logic [DATA_W-1:0]   sh_data;
    logic [SPC-1:0]      low_mask;
    int unsigned         sh_amt;

    logic in_fire;
    logic out_free;

    // With one lane per word there is nothing to shift.
    assign in_shift = (SPC > 1) ? i_shift : '0;

    assign out_free = !o_valid_q || o_ready;
    assign i_ready  = rst_n && (state_q != StFlush) && out_free;
    assign in_fire  = i_valid && i_ready;

    // Lane shifter: output lane n = concatenated {current, previous} lane n + SPC - s.
    always_comb begin
        sh_s    = shift_q;
        sh_cur  = i_data;
        sh_prev = carry_q;
        if (state_q == StSop) begin
            // First word of a packet: nothing carried in, shift taken live.
            sh_s    = in_shift;
            sh_prev = '0;
        end else if (state_q == StFlush) begin
            sh_cur = '0;
        end
        sh_amt  = (SPC - 32'(sh_s)) * SAMP_W;
        sh_wide = {sh_cur, sh_prev} >> sh_amt;
        sh_data = sh_wide[DATA_W-1:0];
        for (int unsigned n = 0; n < SPC; n++) begin
            low_mask[n] = (n < 32'(sh_s));
        end
    end

    // Packet state machine and output register next-state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        carry_d   = carry_q;
        o_data_d  = o_data_q;
        o_user_d  = o_user_q;
        o_mask_d  = o_mask_q;
        o_last_d  = o_last_q;
        o_valid_d = o_valid_q;

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        case (state_q)
            StSop, StBody: begin
                if (in_fire) begin
                    o_data_d  = sh_data;
                    o_user_d  = i_user;
                    o_valid_d = 1'b1;
                    o_mask_d  = (state_q == StSop) ? ~low_mask : '1;
                    carry_d   = i_data;
                    shift_d   = sh_s;
                    if (!i_last) begin
                        o_last_d = 1'b0;
                        state_d  = StBody;
                    end else if (sh_s == '0) begin
                        o_last_d = 1'b1;
                        state_d  = StSop;
                    end else begin
                        // Carry still holds s samples; emit them as a flush word next.
                        o_last_d = 1'b0;
                        state_d  = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_free) begin
                    // o_user_d keeps the last input word's sideband.
                    o_data_d  = sh_data;
                    o_mask_d  = low_mask;
                    o_last_d  = 1'b1;
                    o_valid_d = 1'b1;
                    carry_d   = '0;
                    state_d   = StSop;
                end
            end
            default: begin
                state_d = StSop;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StSop;
            shift_q   <= '0;
            carry_q   <= '0;
            o_data_q  <= '0;
            o_user_q  <= '0;
            o_mask_q  <= '0;
            o_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            carry_q   <= carry_d;
            o_data_q  <= o_data_d;
            o_user_q  <= o_user_d;
            o_mask_q  <= o_mask_d;
            o_last_q  <= o_last_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_user  = o_user_q;
    assign o_mask  = o_mask_q;
    assign o_last  = o_last_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_unalign_samples.sv
// Bench for unalign_samples (SAMP_W=8, SPC=4): directed vector table, back-to-back
// packets, mid-packet reset, and randomized packets with backpressure checked
// against a packet-level model (prepend s empty lanes, pad, split into words).
module tb_unalign_samples;

    localparam int SAMP_W = 8;
    localparam int SPC    = 4;
    localparam int USER_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_data = '0;
    logic [15:0] i_user = '0;
    logic [1:0]  i_shift = '0;
    logic        i_last = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] o_data;
    logic [15:0] o_user;
    logic [3:0]  o_mask;
    logic        o_last;
    logic        o_valid;
    logic        o_ready = 1'b1;

    unalign_samples #(
        .SAMP_W(SAMP_W),
        .SPC   (SPC),
        .USER_W(USER_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .i_user (i_user),
        .i_shift(i_shift),
        .i_last (i_last),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_user (o_user),
        .o_mask (o_mask),
        .o_last (o_last),
        .o_valid(o_valid),
        .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
        logic [15:0] user;
    } exp_t;

    typedef struct {
        int          shift;
        int          nin;
        logic [63:0] din;
        logic [31:0] uin;
        int          nout;
        logic [95:0] od;
        logic [11:0] om;
        logic [2:0]  ol;
        logic [47:0] ou;
    } vec_t;

    exp_t        exp_q[$];
    int          xfer_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
    logic        stall_pend = 1'b0;
    logic [52:0] held;
    exp_t        mon_e;

    logic [31:0] pkt_d[4];
    logic [15:0] pkt_u[4];
    int          pkt_n;

    vec_t        vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (ready_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = 1'($urandom_range(0, 1));
            default: o_ready = 1'b0;
        endcase
    end

    // Output monitor: stall stability and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && stall_pend) begin
            check("hold_stable", 64'({o_valid, o_data, o_mask, o_last, o_user}),
                  64'({1'b1, held}));
        end
        stall_pend = rst_n && o_valid && !o_ready;
        held       = {o_data, o_mask, o_last, o_user};
        if (rst_n && o_valid && o_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h, expected no output", o_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_word", 64'({o_data, o_mask, o_last, o_user}),
                      64'({mon_e.data, mon_e.mask, mon_e.last, mon_e.user}));
            end
        end
    end

    // Reference: the packet's samples placed after s empty lanes, padded to whole words.
    task automatic model_packet(input int s);
        int   nl;
        int   nw;
        int   idx;
        exp_t e;
        nl = s + pkt_n * SPC;
        nw = (nl + SPC - 1) / SPC;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            e.mask = '0;
            for (int l = 0; l < SPC; l++) begin
                idx = w * SPC + l;
                if (idx >= s && idx < nl) begin
                    e.data[l*SAMP_W +: SAMP_W] =
                        pkt_d[(idx - s) / SPC][((idx - s) % SPC) * SAMP_W +: SAMP_W];
                    e.mask[l] = 1'b1;
                end
            end
            e.user = pkt_u[(w < pkt_n) ? w : pkt_n - 1];
            e.last = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic [15:0] u, input logic [1:0] s,
                             input logic last);
        int t;
        i_data  = d;
        i_user  = u;
        i_shift = s;
        i_last  = last;
        i_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!i_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!i_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: i_ready stuck at 0, required 1");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_packet(input int s);
        model_packet(s);
        for (int k = 0; k < pkt_n; k++) begin
            // i_shift on later words is junk; only the first word's value matters.
            send_word(pkt_d[k], pkt_u[k], (k == 0) ? 2'(s) : 2'($urandom_range(0, 3)),
                      k == pkt_n - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{1, 2, {32'h07060504, 32'h03020100}, {16'h2222, 16'h1111}, 3,
                    {32'h00000007, 32'h06050403, 32'h02010000},
                    {4'b0001, 4'b1111, 4'b1110}, 3'b100, {16'h2222, 16'h2222, 16'h1111}};
        vecs[1] = '{0, 2, {32'h07060504, 32'h03020100}, {16'h2222, 16'h1111}, 2,
                    {32'h00000000, 32'h07060504, 32'h03020100},
                    {4'b0000, 4'b1111, 4'b1111}, 3'b010, {16'h0000, 16'h2222, 16'h1111}};
        vecs[2] = '{3, 1, {32'h00000000, 32'h03020100}, {16'h0000, 16'h1111}, 2,
                    {32'h00000000, 32'h00030201, 32'h00000000},
                    {4'b0000, 4'b0111, 4'b1000}, 3'b010, {16'h0000, 16'h1111, 16'h1111}};
        vecs[3] = '{2, 2, {32'h17161514, 32'h13121110}, {16'h2222, 16'h1111}, 3,
                    {32'h00001716, 32'h15141312, 32'h11100000},
                    {4'b0011, 4'b1111, 4'b1100}, 3'b100, {16'h2222, 16'h2222, 16'h1111}};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(o_valid), 64'(0));
        check("reset_last", 64'(o_last), 64'(0));
        check("reset_mask", 64'(o_mask), 64'(0));
        check("reset_data", 64'(o_data), 64'(0));
        check("reset_user", 64'(o_user), 64'(0));
        check("reset_ready", 64'(i_ready), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < vecs[v].nout; k++) begin
                e.data = vecs[v].od[k*32 +: 32];
                e.mask = vecs[v].om[k*4 +: 4];
                e.last = vecs[v].ol[k];
                e.user = vecs[v].ou[k*16 +: 16];
                exp_q.push_back(e);
            end
            for (int k = 0; k < vecs[v].nin; k++) begin
                send_word(vecs[v].din[k*32 +: 32], vecs[v].uin[k*16 +: 16],
                          (k == 0) ? 2'(vecs[v].shift) : 2'(vecs[v].shift + 1),
                          k == vecs[v].nin - 1);
            end
            wait_drain();
        end

        // Back-to-back: s=2 two-word packet, then s=1 single word; flush then next SOP.
        xfer_cyc.delete();
        pkt_n = 2;
        pkt_d[0] = 32'h23222120; pkt_d[1] = 32'h27262524;
        pkt_u[0] = 16'h3001;     pkt_u[1] = 16'h3002;
        send_packet(2);
        pkt_n = 1;
        pkt_d[0] = 32'h33323130; pkt_u[0] = 16'h3003;
        send_packet(1);
        wait_drain();
        check("b2b_count", 64'(xfer_cyc.size()), 64'(5));
        if (xfer_cyc.size() >= 4) begin
            check("b2b_gap", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'(1));
        end

        // Mid-packet reset with s=2, output stalled.
        ready_mode = 2;
        @(posedge clk);
        #1;
        send_word(32'h43424140, 16'h4001, 2'd2, 1'b0);
        @(negedge clk);
        check("pre_reset_valid", 64'(o_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(o_valid), 64'(0));
        check("async_reset_ready", 64'(i_ready), 64'(0));
        @(posedge clk);
        #1;
        check("in_reset_outputs", 64'({o_data, o_mask, o_last, o_user}), 64'(0));
        ready_mode = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pkt_n = 1;
        pkt_d[0] = 32'h0B0A0908; pkt_u[0] = 16'h4002;
        send_packet(1);
        wait_drain();

        // Randomized packets and shifts with 50% output backpressure.
        ready_mode = 1;
        for (int p = 0; p < 1000; p++) begin
            pkt_n = $urandom_range(1, 4);
            for (int k = 0; k < pkt_n; k++) begin
                pkt_d[k] = $urandom;
                pkt_u[k] = 16'($urandom);
            end
            send_packet($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();
        ready_mode = 0;
        wait_drain();
        check("final_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
